ddr3_wr_ctrl_param: RTL and testbench

Parametrised next-generation DDR3 write controller.
- Pops framed fills from the ADC-side first-word-fall-through FIFO and writes each word to DDR3 at a burst-aligned address taken from the fill header.
- Throttles address commands against accepted data.
- Posts the header to the fill-header FIFO when the fill completes.
- Adds header-FIFO backpressure, graceful stop, optional resync after a bad header tag, and status counters.

---
 rtl/ddr3_wr_pkg.sv | 24 ++
 rtl/ddr3_wr_throttle.sv | 31 +++
 rtl/ddr3_wr_ctrl_param.sv | 170 +++++++++++++++++
 tb/tb_ddr3_wr_ctrl_param.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_wr_pkg.sv
// DDR3 write-path shared definitions.
// Header layout is also used by the header producer and read side.
package ddr3_wr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TST_HDR,
    SYNC_ERR,
    RESYNC,
    INIT,
    WRITE,
    HDR_WAIT,
    DONE
  } state_t;

  localparam logic [1:0] HDR_TAG = 2'b01;

  localparam int HDR_START_LSB   = 35;
  localparam int HDR_START_W     = 23;
  localparam int HDR_CNT_LSB     = 64;
  localparam int HDR_CNT_W       = 21;
  localparam int HDR_EXTRA_WORDS = 2;

endpackage

// File: rtl/ddr3_wr_throttle.sv
// Tracks data words accepted ahead of their write commands.
// Data stalls at AHEAD_MAX; commands only issue for buffered data.
module ddr3_wr_throttle #(
  parameter int AHEAD_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic data_accept,
  input  logic addr_accept,
  output logic data_allow,
  output logic addr_allow
);

  logic [7:0] ahead;

  // up on data only, down on address only
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ahead <= 8'd0;
    end else if (data_accept && !addr_accept) begin
      ahead <= ahead + 8'd1;
    end else if (addr_accept && !data_accept) begin
      ahead <= ahead - 8'd1;
    end
  end

  assign data_allow = ahead < 8'(AHEAD_MAX);
  assign addr_allow = ahead != 8'd0;

endmodule

// File: rtl/ddr3_wr_ctrl_param.sv
// Moves framed fills from the ADC FIFO into DDR3 and posts the
// fill header once the whole fill has been written.
module ddr3_wr_ctrl_param #(
  parameter int DATA_W            = 128,
  parameter int ADDR_W            = 26,
  parameter int COL_LSB_W         = 3,
  parameter int START_W           = ddr3_wr_pkg::HDR_START_W,
  parameter int START_LSB         = ddr3_wr_pkg::HDR_START_LSB,
  parameter int CNT_W             = ddr3_wr_pkg::HDR_CNT_W,
  parameter int CNT_LSB           = ddr3_wr_pkg::HDR_CNT_LSB,
  parameter int EXTRA_WORDS       = ddr3_wr_pkg::HDR_EXTRA_WORDS,
  parameter logic [1:0] HDR_TAG   = ddr3_wr_pkg::HDR_TAG,
  parameter int AHEAD_MAX         = 16,
  parameter bit RESYNC_EN         = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acq_enabled,
  input  logic [DATA_W-1:0] ddr3_wr_fifo_dat,
  input  logic              ddr3_wr_fifo_empty,
  output logic              ddr3_wr_fifo_rd_en,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  output logic [ADDR_W-1:0] ddr3_wr_addr,
  output logic              wr_app_en,
  input  logic              wr_app_rdy,
  output logic [DATA_W-1:0] fill_header_wr_dat,
  output logic              fill_header_wr_en,
  input  logic              fill_header_full,
  output logic              ddr3_wr_busy,
  output logic              ddr3_wr_sync_err,
  output logic [15:0]       sync_err_cnt,
  output logic [31:0]       fill_cnt
);
  import ddr3_wr_pkg::*;

  state_t             state;
  logic [START_W-1:0] address_gen;
  logic [CNT_W-1:0]   burst_cntr;
  logic [CNT_W-1:0]   addr_cntr;
  logic [CNT_W-1:0]   hdr_cnt;
  logic               tag_ok;
  logic               in_write;
  logic               in_resync;
  logic               data_accept;
  logic               addr_accept;
  logic               data_allow;
  logic               addr_allow;

  assign tag_ok    = ddr3_wr_fifo_dat[DATA_W-1 -: 2] == HDR_TAG;
  assign in_write  = state == WRITE;
  assign in_resync = state == RESYNC;
  assign hdr_cnt   = fill_header_wr_dat[CNT_LSB +: CNT_W]
                   + CNT_W'(EXTRA_WORDS);

  assign app_wdf_data = ddr3_wr_fifo_dat;
  assign app_wdf_wren = in_write && !ddr3_wr_fifo_empty
                     && burst_cntr != '0 && data_allow;
  assign app_wdf_end  = app_wdf_wren;
  assign data_accept  = app_wdf_wren && app_wdf_rdy;

  assign wr_app_en    = in_write && addr_allow && addr_cntr != '0;
  assign addr_accept  = wr_app_en && wr_app_rdy;
  assign ddr3_wr_addr = {address_gen, {COL_LSB_W{1'b0}}};

  // junk words are dropped only while hunting for a header
  assign ddr3_wr_fifo_rd_en = data_accept
    || (in_resync && !ddr3_wr_fifo_empty && !tag_ok);

  ddr3_wr_throttle #(
    .AHEAD_MAX(AHEAD_MAX)
  ) u_throttle (
    .clk        (clk),
    .reset      (reset),
    .clear      (state == INIT),
    .data_accept(data_accept),
    .addr_accept(addr_accept),
    .data_allow (data_allow),
    .addr_allow (addr_allow)
  );

  // fill sequencing, burst/address counters and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      address_gen        <= '0;
      burst_cntr         <= '0;
      addr_cntr          <= '0;
      fill_header_wr_dat <= '0;
      fill_header_wr_en  <= 1'b0;
      ddr3_wr_busy       <= 1'b0;
      ddr3_wr_sync_err   <= 1'b0;
      sync_err_cnt       <= '0;
      fill_cnt           <= '0;
    end else begin
      ddr3_wr_sync_err  <= 1'b0;
      fill_header_wr_en <= 1'b0;
      if (data_accept) begin
        burst_cntr <= burst_cntr - CNT_W'(1);
      end
      if (addr_accept) begin
        addr_cntr   <= addr_cntr - CNT_W'(1);
        address_gen <= address_gen + START_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (!ddr3_wr_fifo_empty && acq_enabled) begin
            state        <= TST_HDR;
            ddr3_wr_busy <= 1'b1;
          end
        end
        TST_HDR: begin
          fill_header_wr_dat <= ddr3_wr_fifo_dat;
          if (tag_ok) begin
            state <= INIT;
          end else begin
            if (sync_err_cnt != 16'hFFFF) begin
              sync_err_cnt <= sync_err_cnt + 16'd1;
            end
            ddr3_wr_sync_err <= 1'b1;
            state <= RESYNC_EN ? RESYNC : SYNC_ERR;
          end
        end
        SYNC_ERR: begin
          ddr3_wr_sync_err <= 1'b1;
        end
        RESYNC: begin
          if (!ddr3_wr_fifo_empty && tag_ok) begin
            state <= TST_HDR;
          end
        end
        INIT: begin
          address_gen <=
            fill_header_wr_dat[START_LSB +: START_W];
          burst_cntr <= hdr_cnt;
          addr_cntr  <= hdr_cnt;
          state      <= WRITE;
        end
        WRITE: begin
          if (burst_cntr == '0 && addr_cntr == '0) begin
            if (!fill_header_full) begin
              state             <= DONE;
              fill_header_wr_en <= 1'b1;
              fill_cnt          <= fill_cnt + 32'd1;
            end else begin
              state <= HDR_WAIT;
            end
          end
        end
        HDR_WAIT: begin
          if (!fill_header_full) begin
            state             <= DONE;
            fill_header_wr_en <= 1'b1;
            fill_cnt          <= fill_cnt + 32'd1;
          end
        end
        DONE: begin
          state        <= IDLE;
          ddr3_wr_busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_wr_ctrl_param.sv
// Directed bench for ddr3_wr_ctrl_param.
// Second instance runs with sticky sync errors.
module tb_ddr3_wr_ctrl_param;

  logic         clk = 1'b0;
  logic         reset;
  logic         acq_enabled;
  logic         acq2;
  logic [127:0] fifo_dat;
  logic         fifo_empty;
  logic         wdf_rdy;
  logic         app_rdy;
  logic         hdr_full;

  logic         rd_en, wren, wend, app_en;
  logic [127:0] wdf_data, hdr_dat;
  logic [25:0]  addr;
  logic         hdr_wr_en, busy, sync_err;
  logic [15:0]  err_cnt;
  logic [31:0]  fcnt;

  logic         rd_en2, wren2, wend2, app_en2;
  logic [127:0] wdf_data2, hdr_dat2;
  logic [25:0]  addr2;
  logic         hdr_wr_en2, busy2, sync_err2;
  logic [15:0]  err_cnt2;
  logic [31:0]  fcnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr3_wr_ctrl_param dut (
    .clk(clk), .reset(reset), .acq_enabled(acq_enabled),
    .ddr3_wr_fifo_dat(fifo_dat),
    .ddr3_wr_fifo_empty(fifo_empty),
    .ddr3_wr_fifo_rd_en(rd_en),
    .app_wdf_data(wdf_data), .app_wdf_wren(wren),
    .app_wdf_end(wend), .app_wdf_rdy(wdf_rdy),
    .ddr3_wr_addr(addr), .wr_app_en(app_en),
    .wr_app_rdy(app_rdy),
    .fill_header_wr_dat(hdr_dat),
    .fill_header_wr_en(hdr_wr_en),
    .fill_header_full(hdr_full),
    .ddr3_wr_busy(busy), .ddr3_wr_sync_err(sync_err),
    .sync_err_cnt(err_cnt), .fill_cnt(fcnt)
  );

  ddr3_wr_ctrl_param #(.RESYNC_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .acq_enabled(acq2),
    .ddr3_wr_fifo_dat(fifo_dat),
    .ddr3_wr_fifo_empty(fifo_empty),
    .ddr3_wr_fifo_rd_en(rd_en2),
    .app_wdf_data(wdf_data2), .app_wdf_wren(wren2),
    .app_wdf_end(wend2), .app_wdf_rdy(wdf_rdy),
    .ddr3_wr_addr(addr2), .wr_app_en(app_en2),
    .wr_app_rdy(app_rdy),
    .fill_header_wr_dat(hdr_dat2),
    .fill_header_wr_en(hdr_wr_en2),
    .fill_header_full(hdr_full),
    .ddr3_wr_busy(busy2), .ddr3_wr_sync_err(sync_err2),
    .sync_err_cnt(err_cnt2), .fill_cnt(fcnt2)
  );

  // first-word-fall-through FIFO model
  logic [127:0] mem [256];
  logic [7:0]   rd_ptr = 8'd0;
  logic [7:0]   wr_ptr;

  assign fifo_dat   = mem[rd_ptr];
  assign fifo_empty = rd_ptr == wr_ptr;

  always @(posedge clk) begin
    if (rd_en && !fifo_empty) rd_ptr <= rd_ptr + 8'd1;
  end

  // handshake monitor
  int           n_data = 0, n_addr = 0, n_push = 0;
  int           n_pop = 0, n_err = 0;
  logic [127:0] data_log [256];
  logic [25:0]  addr_log [256];

  always @(posedge clk) begin
    if (wren && wdf_rdy) begin
      data_log[n_data[7:0]] <= wdf_data;
      n_data <= n_data + 1;
    end
    if (app_en && app_rdy) begin
      addr_log[n_addr[7:0]] <= addr;
      n_addr <= n_addr + 1;
    end
    if (hdr_wr_en) n_push <= n_push + 1;
    if (rd_en) n_pop <= n_pop + 1;
    if (sync_err) n_err <= n_err + 1;
  end

  function automatic logic [127:0] mk_hdr(
    input logic [1:0] tag, input logic [22:0] start,
    input logic [20:0] cnt);
    logic [127:0] h;
    h = '0;
    h[127:126] = tag;
    h[57:35]   = start;
    h[84:64]   = cnt;
    h[7:0]     = 8'h5A;
    return h;
  endfunction

  function automatic logic [127:0] word(input int i);
    return {64'h3000_0000_0000_0000 + 64'(i), 64'(i)};
  endfunction

  task automatic push(input logic [127:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    acq_enabled = 1'b0;
    acq2 = 1'b0;
    wdf_rdy = 1'b1;
    app_rdy = 1'b1;
    hdr_full = 1'b0;
    repeat (3) @(negedge clk);
    wr_ptr = rd_ptr;
    reset = 1'b0;
  endtask

  task automatic wait_fill(input int max, output bit ok);
    bit seen;
    seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    for (int i = 0; i < max && seen && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset_and_basic();
    logic [127:0] h;
    int d0, a0, p0, bad;
    bit ok;
    do_reset();
    h = mk_hdr(2'b01, 23'h000010, 21'd4);
    push(h);
    for (int i = 0; i < 5; i++) push(word(i));
    #1;
    checks++;
    if ({busy, wren, app_en, rd_en, hdr_wr_en, sync_err}
        !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=000000",
        {busy, wren, app_en, rd_en, hdr_wr_en, sync_err});
    end
    checks++;
    if (addr !== 26'd0 || hdr_dat !== 128'd0) begin
      failures++;
      $display("FAIL reset_regs addr=%h hdr=%h exp=0", addr, hdr_dat);
    end
    checks++;
    if (fcnt !== 32'd0 || err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_cnt fill=%0d err=%0d exp=0", fcnt, err_cnt);
    end
    checks++;
    if (wdf_data !== h) begin
      failures++;
      $display("FAIL wdf_follow got=%h exp=%h", wdf_data, h);
    end
    d0 = n_data; a0 = n_addr; p0 = n_push;
    acq_enabled = 1'b1;
    wait_fill(60, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_timeout got=busy exp=idle");
    end
    checks++;
    if (n_data - d0 !== 6 || n_addr - a0 !== 6) begin
      failures++;
      $display("FAIL basic_hs data=%0d addr=%0d exp=6/6",
        n_data - d0, n_addr - a0);
    end
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (addr_log[a0 + i] !== 26'h80 + 26'(8 * i)) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL basic_addr got=%0d_bad first=%h exp=80",
        bad, addr_log[a0]);
    end
    checks++;
    if (data_log[d0] !== h || data_log[d0 + 5] !== word(4)) begin
      failures++;
      $display("FAIL basic_data got=%h exp=%h", data_log[d0], h);
    end
    checks++;
    if (n_push - p0 !== 1 || fcnt !== 32'd1 || hdr_dat !== h) begin
      failures++;
      $display("FAIL basic_push push=%0d fill=%0d exp=1/1",
        n_push - p0, fcnt);
    end
    acq_enabled = 1'b0;
  endtask

  task automatic test_throttle();
    int d0, a0;
    bit ok;
    do_reset();
    push(mk_hdr(2'b01, 23'h000100, 21'd20));
    for (int i = 0; i < 21; i++) push(word(10 + i));
    d0 = n_data; a0 = n_addr;
    app_rdy = 1'b0;
    acq_enabled = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (n_data - d0 !== 16 || n_addr - a0 !== 0) begin
      failures++;
      $display("FAIL ahead_max data=%0d addr=%0d exp=16/0",
        n_data - d0, n_addr - a0);
    end
    checks++;
    if (wren !== 1'b0 || app_en !== 1'b1) begin
      failures++;
      $display("FAIL ahead_stall wren=%b app_en=%b exp=0/1",
        wren, app_en);
    end
    app_rdy = 1'b1;
    @(negedge clk);
    app_rdy = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (n_data - d0 !== 17 || n_addr - a0 !== 1) begin
      failures++;
      $display("FAIL ahead_step data=%0d addr=%0d exp=17/1",
        n_data - d0, n_addr - a0);
    end
    app_rdy = 1'b1;
    wait_fill(80, ok);
    checks++;
    if (!ok || n_data - d0 !== 22 || n_addr - a0 !== 22) begin
      failures++;
      $display("FAIL ahead_total data=%0d addr=%0d exp=22/22",
        n_data - d0, n_addr - a0);
    end
    checks++;
    if (addr_log[a0] !== 26'h800 || addr_log[a0 + 21] !== 26'h8A8) begin
      failures++;
      $display("FAIL ahead_addr got=%h,%h exp=800,8a8",
        addr_log[a0], addr_log[a0 + 21]);
    end
    acq_enabled = 1'b0;
  endtask

  task automatic test_resync();
    logic [127:0] h;
    int d0, a0, po0, e0;
    bit ok;
    do_reset();
    h = mk_hdr(2'b01, 23'h000020, 21'd1);
    push(mk_hdr(2'b11, 23'h000020, 21'd1));
    for (int i = 0; i < 3; i++) push(word(100 + i));
    push(h);
    push(word(200));
    push(word(201));
    d0 = n_data; a0 = n_addr; po0 = n_pop; e0 = n_err;
    acq_enabled = 1'b1;
    acq2 = 1'b1;
    wait_fill(80, ok);
    checks++;
    if (!ok || n_pop - po0 !== 7 || n_data - d0 !== 3) begin
      failures++;
      $display("FAIL resync_pops pops=%0d data=%0d exp=7/3",
        n_pop - po0, n_data - d0);
    end
    checks++;
    if (data_log[d0] !== h || addr_log[a0] !== 26'h100) begin
      failures++;
      $display("FAIL resync_fill got=%h exp=100", addr_log[a0]);
    end
    checks++;
    if (err_cnt !== 16'd1 || n_err - e0 !== 1 || sync_err !== 1'b0) begin
      failures++;
      $display("FAIL resync_err cnt=%0d pulses=%0d exp=1/1",
        err_cnt, n_err - e0);
    end
    checks++;
    if (fcnt !== 32'd1 || fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL resync_done fill=%0d empty=%b exp=1/1",
        fcnt, fifo_empty);
    end
    acq2 = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (sync_err2 !== 1'b1 || busy2 !== 1'b1 || err_cnt2 !== 16'd1) begin
      failures++;
      $display("FAIL sticky_err err=%b busy=%b cnt=%0d exp=1/1/1",
        sync_err2, busy2, err_cnt2);
    end
    acq_enabled = 1'b0;
  endtask

  task automatic test_hdr_full();
    int a0, p0;
    bit got;
    do_reset();
    push(mk_hdr(2'b01, 23'h000040, 21'd1));
    push(word(300));
    push(word(301));
    a0 = n_addr; p0 = n_push;
    hdr_full = 1'b1;
    acq_enabled = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (n_addr - a0 == 3) got = 1'b1;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (!got || busy !== 1'b1 || hdr_wr_en !== 1'b0
        || n_push - p0 !== 0) begin
      failures++;
      $display("FAIL hdr_wait busy=%b push=%0d exp=1/0",
        busy, n_push - p0);
    end
    hdr_full = 1'b0;
    @(negedge clk);
    checks++;
    if (hdr_wr_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL hdr_push wr_en=%b busy=%b exp=1/1",
        hdr_wr_en, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_push - p0 !== 1 || fcnt !== 32'd1) begin
      failures++;
      $display("FAIL hdr_done busy=%b push=%0d exp=0/1",
        busy, n_push - p0);
    end
    acq_enabled = 1'b0;
  endtask

  task automatic test_addr_wrap();
    int d0, a0;
    bit ok;
    do_reset();
    push(mk_hdr(2'b01, 23'h7FFFFF, 21'd0));
    push(word(400));
    d0 = n_data; a0 = n_addr;
    acq_enabled = 1'b1;
    wait_fill(40, ok);
    checks++;
    if (!ok || n_data - d0 !== 2 || n_addr - a0 !== 2) begin
      failures++;
      $display("FAIL wrap_hs data=%0d addr=%0d exp=2/2",
        n_data - d0, n_addr - a0);
    end
    checks++;
    if (addr_log[a0] !== 26'h3FFFFF8 || addr_log[a0 + 1] !== 26'h0) begin
      failures++;
      $display("FAIL wrap_addr got=%h,%h exp=3fffff8,0",
        addr_log[a0], addr_log[a0 + 1]);
    end
    acq_enabled = 1'b0;
  endtask

  task automatic test_graceful_stop();
    int d0, po0;
    bit seen, idle, saw_busy;
    do_reset();
    push(mk_hdr(2'b01, 23'h000060, 21'd3));
    for (int i = 0; i < 4; i++) push(word(500 + i));
    push(mk_hdr(2'b01, 23'h000080, 21'd0));
    push(word(600));
    d0 = n_data; po0 = n_pop;
    acq_enabled = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    repeat (2) @(negedge clk);
    acq_enabled = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    checks++;
    if (!seen || !idle || n_data - d0 !== 5 || fcnt !== 32'd1) begin
      failures++;
      $display("FAIL stop_fill data=%0d fill=%0d exp=5/1",
        n_data - d0, fcnt);
    end
    saw_busy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b0 || n_pop - po0 !== 5 || fifo_empty !== 1'b0) begin
      failures++;
      $display("FAIL stop_idle busy=%b pops=%0d exp=0/5",
        saw_busy, n_pop - po0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    wr_ptr = 8'd0;
    reset = 1'b1;
    acq_enabled = 1'b0;
    acq2 = 1'b0;
    wdf_rdy = 1'b1;
    app_rdy = 1'b1;
    hdr_full = 1'b0;
    test_reset_and_basic();
    test_throttle();
    test_resync();
    test_hdr_full();
    test_addr_wrap();
    test_graceful_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
